// File: rtl/alu_issue.sv
// alu_issue: decodes instructions into ALU commands/operands and queues them in a 2-entry FIFO toward execute.
module alu_issue #(
  parameter int WORD_LEN    = 32,
  parameter int EXE_CMD_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [5:0]             opcode,
  input  logic [WORD_LEN-1:0]    rs_val,
  input  logic [WORD_LEN-1:0]    rt_val,
  input  logic [15:0]            imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXE_CMD_LEN-1:0] exe_cmd,
  output logic [WORD_LEN-1:0]    val1,
  output logic [WORD_LEN-1:0]    val2,
  output logic                   illegal,
  output logic [15:0]            issue_cnt
);
  logic [EXE_CMD_LEN-1:0] d_cmd;
  logic [WORD_LEN-1:0]    d_v1, d_v2;
  logic                   d_ill;
  logic [EXE_CMD_LEN-1:0] cmd_q [2];
  logic [WORD_LEN-1:0]    v1_q  [2];
  logic [WORD_LEN-1:0]    v2_q  [2];
  logic                   ill_q [2];
  logic                   wp, rp, push, pop;
  logic [1:0]             count, cnt_nxt;

  always_comb begin
    d_cmd = '1;
    d_ill = 1'b0;
    case (opcode)
      6'b000001, 6'b100000: d_cmd = EXE_CMD_LEN'(4'b0000);
      6'b000011, 6'b100001: d_cmd = EXE_CMD_LEN'(4'b0010);
      6'b000101:            d_cmd = EXE_CMD_LEN'(4'b0100);
      6'b000110:            d_cmd = EXE_CMD_LEN'(4'b0101);
      6'b000111:            d_cmd = EXE_CMD_LEN'(4'b0110);
      6'b001000:            d_cmd = EXE_CMD_LEN'(4'b0111);
      6'b001001, 6'b001010: d_cmd = EXE_CMD_LEN'(4'b1000);
      6'b001011:            d_cmd = EXE_CMD_LEN'(4'b1001);
      6'b001100:            d_cmd = EXE_CMD_LEN'(4'b1010);
      default:              d_ill = 1'b1;
    endcase
    // only ADDI/SUBI among legal opcodes have bit 5 set
    d_v1 = d_ill ? '0 : rs_val;
    d_v2 = d_ill ? '0 : opcode[5] ? {{(WORD_LEN-16){imm[15]}}, imm} : rt_val;
  end

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign cnt_nxt   = count + 2'(push) - 2'(pop);
  assign out_valid = count != 2'd0;
  assign exe_cmd   = out_valid ? cmd_q[rp] : '1;
  assign val1      = out_valid ? v1_q[rp] : '0;
  assign val2      = out_valid ? v2_q[rp] : '0;
  assign illegal   = out_valid & ill_q[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= 2'd0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      in_ready  <= 1'b0;
      issue_cnt <= 16'd0;
    end else begin
      count    <= cnt_nxt;
      in_ready <= cnt_nxt < 2'd2;
      if (push) wp <= ~wp;
      if (pop) begin
        rp        <= ~rp;
        issue_cnt <= issue_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cmd_q[wp] <= d_cmd;
      v1_q[wp]  <= d_v1;
      v2_q[wp]  <= d_v2;
      ill_q[wp] <= d_ill;
    end
  end
endmodule
